// File: rtl/traffic_light_multi.sv
// Multi-approach traffic light controller: round-robin green service with
// min/max green, all-red clearance and a latched pedestrian walk phase.
module traffic_light_multi #(
  parameter int NUM_DIR   = 3,
  parameter int DIR_W     = 2,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int PED_T     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_DIR-1:0]     T,
  input  logic                   ped_req,
  output logic [2*NUM_DIR-1:0]   L,
  output logic [1:0]             S,
  output logic [1:0]             next_S,
  output logic [DIR_W-1:0]       dir,
  output logic                   walk,
  output logic                   ped_pending
);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10,
    ST_PED    = 2'b11
  } state_t;

  localparam int PW = 2 ** DIR_W;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [PW-1:0]     t_pad;
  logic              others, req_other, found;
  logic [DIR_W-1:0]  rr_dir, cand;

  function automatic logic [DIR_W-1:0] inc_dir(input logic [DIR_W-1:0] d);
    return (d == DIR_W'(NUM_DIR - 1)) ? '0 : d + 1'b1;
  endfunction

  // Zero-padded sensor vector so a dynamic index never reads a nonexistent bit.
  assign t_pad = PW'(T);

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    others = 1'b0;
    for (int j = 0; j < NUM_DIR; j++) begin
      if (DIR_W'(j) != dir) others = others | T[j];
    end
    req_other = others | ped_pending;
  end

  always_comb begin
    rr_dir = inc_dir(dir);
    found  = 1'b0;
    cand   = dir;
    for (int k = 1; k < NUM_DIR; k++) begin
      cand = inc_dir(cand);
      if (!found && t_pad[cand]) begin
        rr_dir = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_GREEN: begin
        if (cnt >= CNT_W'(GREEN_MIN - 1) && req_other &&
            (!t_pad[dir] || cnt >= CNT_W'(GREEN_MAX - 1)))
          state_nxt = ST_YELLOW;
      end
      ST_YELLOW: if (cnt == CNT_W'(YELLOW_T - 1)) state_nxt = ST_ALLRED;
      ST_ALLRED: if (cnt == CNT_W'(ALLRED_T - 1))
                   state_nxt = ped_pending ? ST_PED : ST_GREEN;
      ST_PED:    if (cnt == CNT_W'(PED_T - 1)) state_nxt = ST_GREEN;
      default:   state_nxt = ST_GREEN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_GREEN;
      cnt         <= '0;
      dir         <= '0;
      ped_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + 1'b1;
      if (state_nxt == ST_GREEN && state != ST_GREEN) dir <= rr_dir;
      // Entering the walk phase consumes the request; a new press that cycle is dropped.
      if (state == ST_ALLRED && state_nxt == ST_PED) ped_pending <= 1'b0;
      else if (ped_req && state != ST_PED)            ped_pending <= 1'b1;
    end
  end

  always_comb begin
    L = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      L[2*i +: 2] = 2'b10;
      if (DIR_W'(i) == dir) begin
        if (state == ST_GREEN)       L[2*i +: 2] = 2'b00;
        else if (state == ST_YELLOW) L[2*i +: 2] = 2'b01;
      end
    end
  end

  assign S      = state;
  assign next_S = state_nxt;
  assign walk   = (state == ST_PED);

endmodule

// File: tb/tb_traffic_light_multi.sv
// Directed bench for traffic_light_multi: expected per-edge outputs are queued
// as stimulus is applied and popped/compared one time unit after each edge.
module tb_traffic_light_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] T;
  logic       ped_req;
  logic [5:0] L;
  logic [1:0] S, next_S;
  logic [1:0] dir;
  logic       walk, ped_pending;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] s;
    logic [1:0] d;
    logic [5:0] l;
    logic       w;
    logic       p;
    string      tag;
  } exp_t;

  exp_t sb[$];

  traffic_light_multi dut (
    .clk(clk), .rst(rst), .T(T), .ped_req(ped_req), .L(L), .S(S),
    .next_S(next_S), .dir(dir), .walk(walk), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [5:0] got, input logic [5:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Queue the expected post-edge outputs, advance one edge, then compare.
  task automatic step(input logic [1:0] s, input logic [1:0] d, input logic [5:0] l,
                      input logic w, input logic p, input string tag);
    exp_t e;
    sb.push_back('{s: s, d: d, l: l, w: w, p: p, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp({e.tag, ".S"},    {4'b0, S},           {4'b0, e.s});
    cmp({e.tag, ".dir"},  {4'b0, dir},         {4'b0, e.d});
    cmp({e.tag, ".L"},    L,                   e.l);
    cmp({e.tag, ".walk"}, {5'b0, walk},        {5'b0, e.w});
    cmp({e.tag, ".ped"},  {5'b0, ped_pending}, {5'b0, e.p});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ped_req = 1'b0;
    step(2'b00, 2'd0, 6'b101000, 1'b0, 1'b0, "reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; T = 3'b000; ped_req = 1'b0;

    // Reset state
    do_reset();

    // Green hold: only own approach requests
    T = 3'b001;
    for (int c = 1; c <= 50; c++) step(2'b00, 2'd0, 6'b101000, 1'b0, 1'b0, $sformatf("hold%0d", c));

    // Minimum green
    T = 3'b010;
    do_reset();
    for (int c = 1; c <= 3; c++) step(2'b00, 2'd0, 6'b101000, 1'b0, 1'b0, $sformatf("min_g%0d", c));
    cmp("min.next_S", {4'b0, next_S}, 6'd1);
    step(2'b01, 2'd0, 6'b101001, 1'b0, 1'b0, "min_y4");
    step(2'b01, 2'd0, 6'b101001, 1'b0, 1'b0, "min_y5");
    step(2'b10, 2'd0, 6'b101010, 1'b0, 1'b0, "min_ar6");
    step(2'b00, 2'd1, 6'b100010, 1'b0, 1'b0, "min_g7");

    // Maximum green with skip of idle approach 1, then wrap 2 -> 0
    T = 3'b101;
    do_reset();
    for (int c = 1; c <= 9; c++) step(2'b00, 2'd0, 6'b101000, 1'b0, 1'b0, $sformatf("max_g%0d", c));
    step(2'b01, 2'd0, 6'b101001, 1'b0, 1'b0, "max_y10");
    step(2'b01, 2'd0, 6'b101001, 1'b0, 1'b0, "max_y11");
    step(2'b10, 2'd0, 6'b101010, 1'b0, 1'b0, "max_ar12");
    step(2'b00, 2'd2, 6'b001010, 1'b0, 1'b0, "max_g13");
    for (int c = 14; c <= 22; c++) step(2'b00, 2'd2, 6'b001010, 1'b0, 1'b0, $sformatf("wrap_g%0d", c));
    step(2'b01, 2'd2, 6'b011010, 1'b0, 1'b0, "wrap_y23");
    step(2'b01, 2'd2, 6'b011010, 1'b0, 1'b0, "wrap_y24");
    step(2'b10, 2'd2, 6'b101010, 1'b0, 1'b0, "wrap_ar25");
    step(2'b00, 2'd0, 6'b101000, 1'b0, 1'b0, "wrap_g26");

    // Pedestrian phase
    T = 3'b000;
    do_reset();
    step(2'b00, 2'd0, 6'b101000, 1'b0, 1'b0, "ped_c1");
    ped_req = 1'b1;
    step(2'b00, 2'd0, 6'b101000, 1'b0, 1'b1, "ped_c2");
    ped_req = 1'b0;
    step(2'b00, 2'd0, 6'b101000, 1'b0, 1'b1, "ped_c3");
    step(2'b01, 2'd0, 6'b101001, 1'b0, 1'b1, "ped_y4");
    step(2'b01, 2'd0, 6'b101001, 1'b0, 1'b1, "ped_y5");
    step(2'b10, 2'd0, 6'b101010, 1'b0, 1'b1, "ped_ar6");
    step(2'b11, 2'd0, 6'b101010, 1'b1, 1'b0, "ped_w7");
    step(2'b11, 2'd0, 6'b101010, 1'b1, 1'b0, "ped_w8");
    ped_req = 1'b1;
    step(2'b11, 2'd0, 6'b101010, 1'b1, 1'b0, "ped_w9");
    ped_req = 1'b0;
    step(2'b00, 2'd1, 6'b100010, 1'b0, 1'b0, "ped_g10");
    step(2'b00, 2'd1, 6'b100010, 1'b0, 1'b0, "ped_g11");

    // Reset mid-yellow, then timer restarts from zero
    T = 3'b010;
    do_reset();
    for (int c = 1; c <= 3; c++) step(2'b00, 2'd0, 6'b101000, 1'b0, 1'b0, $sformatf("mid_g%0d", c));
    ped_req = 1'b1;
    step(2'b01, 2'd0, 6'b101001, 1'b0, 1'b1, "mid_y4");
    ped_req = 1'b0;
    do_reset();
    for (int c = 1; c <= 3; c++) step(2'b00, 2'd0, 6'b101000, 1'b0, 1'b0, $sformatf("post_g%0d", c));
    step(2'b01, 2'd0, 6'b101001, 1'b0, 1'b0, "post_y4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_multi.md
Name: traffic_light_multi

Overview:
- Parametrised successor to the two-road traffic light FSM: controls NUM_DIR approaches instead of two.
- Adds min/max green timing, round-robin service of sensor requests, a programmable all-red clearance interval and a latched pedestrian phase.
- Moore machine in the intersection control path; sensor inputs come from the detector interface and light outputs drive the lamp drivers.

Parameters:
- NUM_DIR, 3, number of approaches (2..8).
- DIR_W, 2, width of direction index; must satisfy 2^DIR_W >= NUM_DIR.
- CNT_W, 8, phase timer width.
- GREEN_MIN, 4, minimum green cycles (>=1).
- GREEN_MAX, 10, maximum green cycles when others are waiting (>=GREEN_MIN).
- YELLOW_T, 2, yellow cycles (>=1).
- ALLRED_T, 1, all-red clearance cycles (>=1).
- PED_T, 3, pedestrian walk cycles (>=1).
- All timing values must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- T  in  NUM_DIR  traffic sensor per approach; 1 = vehicle waiting.
- ped_req  in  1  pedestrian button; a single-cycle pulse is sufficient.
- L  out  2*NUM_DIR  light per approach; L[2i+1:2i] is approach i. Encoding: 00 green, 01 yellow, 10 red.
- S  out  2  current state: 00 GREEN, 01 YELLOW, 10 ALLRED, 11 PED.
- next_S  out  2  combinational next state.
- dir  out  DIR_W  approach currently or most recently served.
- walk  out  1  pedestrian walk lamp.
- ped_pending  out  1  latched pedestrian request.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: S=GREEN, dir=0, cnt=0, ped_pending=0. Resulting outputs: L = approach 0 green, all others red; walk=0.
- Reset mid-operation: a reset in any state produces the reset values on the following edge. Any pending request is discarded.
- Outputs: L, walk and dir are decoded from registered state only (Moore); they change on the same edge as S.
- L decode:
  - GREEN: approach dir = 00.
  - YELLOW: approach dir = 01.
  - ALLRED and PED: all approaches = 10.
  - All approaches other than dir are always 10.
  - walk=1 only in PED.
- Timer: cnt resets to 0 on every state change and increments each cycle otherwise, saturating at 2^CNT_W-1.
- Definitions:
  - others = OR of T[j] for j != dir.
  - req_other = others | ped_pending.
- GREEN transitions:
  - Go to YELLOW when cnt >= GREEN_MIN-1 AND req_other AND (T[dir]==0 OR cnt >= GREEN_MAX-1).
  - Otherwise stay. With no competing request, green holds indefinitely.
- YELLOW: go to ALLRED when cnt == YELLOW_T-1.
- ALLRED: when cnt == ALLRED_T-1:
  - If ped_pending, go to PED and clear ped_pending on that edge.
  - Else go to GREEN with dir updated by the round-robin rule.
- PED: when cnt == PED_T-1, go to GREEN with dir updated by the round-robin rule.
- Round-robin rule:
  - New dir is the first j in dir+1, dir+2, ... (mod NUM_DIR), excluding the current dir, with T[j]==1.
  - If none, new dir = (dir+1) mod NUM_DIR.
  - T is sampled on the transition edge.
- ped_pending:
  - Set on any cycle with ped_req=1 while S != PED.
  - ped_req during PED is ignored.
  - If set and clear occur on the same edge (ALLRED to PED), clear wins.
- Wrap-around: dir increments modulo NUM_DIR; values >= NUM_DIR never occur.
- T bits at positions >= NUM_DIR do not exist; no X propagation from unused encodings.

Test Plan:
Defaults throughout. Cycle k = k-th rising edge after rst deasserts.
1. Reset: rst=1 for one edge -> S=00, dir=0, L=6'b101000, walk=0, ped_pending=0.
2. Green hold: T=3'b001 held for 50 cycles -> S stays 00, dir=0, L unchanged throughout.
3. Minimum green: T=3'b010 from reset -> S=YELLOW at cycles 4-5 (L=6'b101001), ALLRED at 6 (L=6'b101010), GREEN dir=1 at 7 (L=6'b100010).
4. Maximum green and skip: T=3'b101 held -> dir0 green until cnt=9; YELLOW at 10-11, ALLRED at 12, GREEN dir=2 at 13 (L=6'b001010). dir1 is skipped.
5. Pedestrian phase: T=0, single ped_req pulse at cycle 1:
   - ped_pending=1 from cycle 2.
   - YELLOW at 4-5, ALLRED at 6.
   - PED at 7-9: walk=1, L=6'b101010, ped_pending=0.
   - GREEN dir=1 at 10.
   - A second ped_req pulse at cycle 8 is ignored.
6. Reset mid-phase: assert rst during the YELLOW of test 3 -> next edge S=00, dir=0, cnt=0, ped_pending=0, L=6'b101000.
